// File: rtl/ofdm_symbol_sequencer.sv
// ofdm_symbol_sequencer: feeds one byte to the free-running FFT wrapper, captures the
// matching symbol's 16 bins and streams them out one bin per valid/ready beat.
module ofdm_symbol_sequencer #(
    parameter int WORD_SIZE      = 16,
    parameter int DATA_LENGTH    = 8,
    parameter int N_BINS         = 16,
    parameter int SKIP_DONES     = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [DATA_LENGTH-1:0]          i_byte,
    input  logic                            i_byte_valid,
    output logic                            o_byte_ready,
    output logic [DATA_LENGTH:0]            o_fft_byte,
    input  logic                            i_fft_done,
    input  logic [N_BINS*2*WORD_SIZE-1:0]   i_bins_flat,
    output logic [WORD_SIZE-1:0]            o_bin_re,
    output logic [WORD_SIZE-1:0]            o_bin_im,
    output logic [3:0]                      o_bin_idx,
    output logic                            o_bin_valid,
    input  logic                            i_bin_ready,
    output logic                            o_bin_last,
    output logic                            o_busy,
    output logic                            o_timeout
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DW = $clog2(SKIP_DONES + 2);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STREAM} state_t;

    state_t                   state_q, state_d;
    logic [3:0]               idx_q, idx_d;
    logic [TW-1:0]            tcnt_q, tcnt_d;
    logic [DW-1:0]            dcnt_q, dcnt_d;
    logic [DATA_LENGTH-1:0]   byte_q, byte_d;
    logic [2*WORD_SIZE-1:0]   bins_q [N_BINS];
    logic [2*WORD_SIZE-1:0]   sel;
    logic                     capture, timeout, stream;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            tcnt_q  <= '0;
            dcnt_q  <= '0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tcnt_q  <= tcnt_d;
            dcnt_q  <= dcnt_d;
            byte_q  <= byte_d;
        end
    end

    // Bins are written only on the qualifying done, so the buffer is frozen while streaming.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int k = 0; k < N_BINS; k++) bins_q[k] <= '0;
        end else if (capture) begin
            for (int k = 0; k < N_BINS; k++) bins_q[k] <= i_bins_flat[k*2*WORD_SIZE +: 2*WORD_SIZE];
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tcnt_d  = tcnt_q;
        dcnt_d  = dcnt_q;
        byte_d  = byte_q;
        capture = 1'b0;
        timeout = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_byte_valid) begin
                    byte_d  = i_byte;
                    idx_d   = '0;
                    tcnt_d  = '0;
                    dcnt_d  = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                tcnt_d = tcnt_q + 1'b1;
                dcnt_d = i_fft_done ? dcnt_q + 1'b1 : dcnt_q;
                // A qualifying done on the last allowed cycle takes priority over the timeout.
                if (i_fft_done && dcnt_q == DW'(SKIP_DONES)) begin
                    capture = 1'b1;
                    state_d = S_STREAM;
                end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_STREAM: begin
                if (i_bin_ready) begin
                    idx_d   = (idx_q == 4'(N_BINS - 1)) ? '0 : idx_q + 1'b1;
                    state_d = (idx_q == 4'(N_BINS - 1)) ? S_IDLE : S_STREAM;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign stream       = (state_q == S_STREAM);
    assign sel          = bins_q[idx_q];
    assign o_byte_ready = (state_q == S_IDLE) && i_rst;
    assign o_fft_byte   = {1'b0, byte_q};
    assign o_bin_valid  = stream;
    assign o_bin_idx    = idx_q;
    assign o_bin_re     = stream ? sel[WORD_SIZE-1:0] : '0;
    assign o_bin_im     = stream ? sel[2*WORD_SIZE-1:WORD_SIZE] : '0;
    assign o_bin_last   = stream && (idx_q == 4'(N_BINS - 1));
    assign o_busy       = (state_q != S_IDLE);
    assign o_timeout    = timeout;

endmodule

// File: tb/tb_ofdm_symbol_sequencer.sv
// tb_ofdm_symbol_sequencer: directed and randomized symbols checked against a
// done-schedule model that predicts capture cycle, timeout and streamed bins.
module tb_ofdm_symbol_sequencer;

    localparam int W = 16, DL = 8, NB = 16, SKIP = 1, TO = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DL-1:0]     byte_i = '0;
    logic              byte_valid = 1'b0;
    logic              byte_ready;
    logic [DL:0]       fft_byte;
    logic              done = 1'b0;
    logic [NB*2*W-1:0] bins_flat = '0;
    logic [W-1:0]      bin_re, bin_im;
    logic [3:0]        bin_idx;
    logic              bin_valid, bin_last, busy, timeout_o;
    logic              bin_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] cur_re [NB], cur_im [NB], exp_re [NB], exp_im [NB];

    ofdm_symbol_sequencer #(
        .WORD_SIZE(W), .DATA_LENGTH(DL), .N_BINS(NB), .SKIP_DONES(SKIP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk(clk), .i_rst(rst_n), .i_byte(byte_i), .i_byte_valid(byte_valid),
        .o_byte_ready(byte_ready), .o_fft_byte(fft_byte), .i_fft_done(done),
        .i_bins_flat(bins_flat), .o_bin_re(bin_re), .o_bin_im(bin_im), .o_bin_idx(bin_idx),
        .o_bin_valid(bin_valid), .i_bin_ready(bin_ready), .o_bin_last(bin_last),
        .o_busy(busy), .o_timeout(timeout_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_bins(input bit directed);
        for (int k = 0; k < NB; k++) begin
            cur_re[k] = directed ? W'(k) : W'($urandom);
            cur_im[k] = directed ? W'(16'h100 + k) : W'($urandom);
            bins_flat[k*2*W +: W]     = cur_re[k];
            bins_flat[k*2*W + W +: W] = cur_im[k];
        end
    endtask

    function automatic logic [127:0] mk(input int a, input int b);
        logic [127:0] m = '0;
        if (a > 0) m[a] = 1'b1;
        if (b > 0) m[b] = 1'b1;
        return m;
    endfunction

    function automatic logic [127:0] rnd_mask(input int one_in);
        logic [127:0] m = '0;
        for (int c = 1; c <= TO; c++) m[c] = ($urandom_range(0, one_in - 1) == 0);
        return m;
    endfunction

    // rmode: 0 always ready, 1 toggle starting low, 2 random
    task automatic symbol(input logic [7:0] b, input logic [127:0] dmask, input bit acc_done,
                          input int rmode, input bit directed, input bit hold_valid,
                          input logic [7:0] nb, input int abort_at);
        int cap = 0, n = 0, k = 0, cyc = 0;
        for (int c = 1; c <= TO; c++) begin
            if (dmask[c]) begin
                n++;
                if (n == SKIP + 1 && cap == 0) cap = c;
            end
        end
        @(negedge clk);
        byte_i = b; byte_valid = 1'b1; done = acc_done; bin_ready = 1'($urandom);
        load_bins(directed);
        #1 chk("acc_ready", byte_ready, 1);
        for (int c = 1; c <= TO; c++) begin
            @(negedge clk);
            byte_valid = hold_valid; byte_i = nb; done = dmask[c];
            load_bins(directed);
            if (c == cap) for (int j = 0; j < NB; j++) begin
                exp_re[j] = cur_re[j];
                exp_im[j] = cur_im[j];
            end
            #1;
            chk("wait_busy", busy, 1);
            chk("wait_ready", byte_ready, 0);
            chk("wait_valid", bin_valid, 0);
            chk("wait_byte", fft_byte, {1'b0, b});
            chk("wait_timeout", timeout_o, (cap == 0 && c == TO));
            if (c == cap) break;
        end
        while (cap != 0 && k < NB) begin
            @(negedge clk);
            cyc++;
            bin_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 0) : 1'($urandom);
            done = 1'($urandom);
            load_bins(1'b0);
            #1;
            chk("st_valid", bin_valid, 1);
            chk("st_idx", bin_idx, k);
            chk("st_re", bin_re, exp_re[k]);
            chk("st_im", bin_im, exp_im[k]);
            chk("st_last", bin_last, (k == NB - 1));
            chk("st_byte", fft_byte, {1'b0, b});
            chk("st_ready", byte_ready, 0);
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_valid", bin_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_byte", fft_byte, 0);
                chk("rst_last", bin_last, 0);
                chk("rst_idx", bin_idx, 0);
                repeat (3) @(negedge clk);
                rst_n = 1'b1; byte_valid = 1'b0; bin_ready = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    done = 1'($urandom);
                    #1;
                    chk("rel_ready", byte_ready, 1);
                    chk("rel_valid", bin_valid, 0);
                    chk("rel_busy", busy, 0);
                end
                return;
            end
            if (bin_ready) k++;
            if (cyc > 400) begin
                chk("stream_budget", cyc, 400);
                break;
            end
        end
        if (cap != 0 && rmode == 1) chk("toggle_cycles", cyc, 2 * NB);
        @(negedge clk);
        byte_valid = 1'b0; bin_ready = 1'($urandom); done = 1'($urandom);
        #1;
        chk("post_ready", byte_ready, 1);
        chk("post_valid", bin_valid, 0);
        chk("post_busy", busy, 0);
        chk("post_timeout", timeout_o, 0);
        chk("post_byte", fft_byte, {1'b0, b});
    endtask

    initial begin
        @(negedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_valid", bin_valid, 0);
        chk("reset_byte", fft_byte, 0);
        chk("reset_timeout", timeout_o, 0);
        chk("reset_re", bin_re, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("reset_ready", byte_ready, 1);

        symbol(8'hA5, mk(1, 5), 1'b0, 0, 1'b1, 1'b0, 8'h00, -1);
        symbol(8'h3C, mk(1, 5), 1'b0, 1, 1'b1, 1'b0, 8'h00, -1);
        symbol(8'h5A, mk(3, 0), 1'b1, 0, 1'b0, 1'b0, 8'h00, -1);
        symbol(8'h11, mk(2, 4), 1'b0, 2, 1'b0, 1'b1, 8'h22, -1);
        symbol(8'h22, mk(1, 2), 1'b0, 0, 1'b0, 1'b0, 8'h00, -1);
        symbol(8'h77, mk(1, 64), 1'b0, 0, 1'b0, 1'b0, 8'h00, -1);
        symbol(8'hC3, mk(1, 2), 1'b0, 0, 1'b0, 1'b0, 8'h00, 5);
        symbol(8'h96, mk(2, 9), 1'b0, 2, 1'b0, 1'b0, 8'h00, -1);
        for (int i = 0; i < 10; i++)
            symbol(8'($urandom), rnd_mask((i % 3 == 0) ? 40 : 6), 1'($urandom),
                   $urandom_range(0, 2), 1'b0, 1'($urandom), 8'($urandom), -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ofdm_symbol_sequencer.md
Name: ofdm_symbol_sequencer

Overview:
Sequences data bytes through the free-running 16-point OFDM FFT wrapper, one symbol at a time. It accepts one byte over a valid/ready handshake and holds it stable on the wrapper's byte input. It then waits for the FFT cycle-done pulse that reflects that byte, snapshots all 16 complex bins, and streams them out serially over a valid/ready handshake. It sits between the byte source (UART/test host) and the FFT wrapper, and gives downstream logic a single-bin-per-beat interface.

Parameters:
WORD_SIZE, 16, width of each re/im bin word
DATA_LENGTH, 8, payload byte width; the wrapper byte port is DATA_LENGTH+1 bits
N_BINS, 16, number of FFT bins buffered and streamed
SKIP_DONES, 1, done pulses discarded after byte acceptance (pipeline flush) before capture
TIMEOUT_CYCLES, 64, cycles allowed from acceptance to qualifying done

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-low reset
i_byte  in  DATA_LENGTH  payload byte
i_byte_valid  in  1  byte offered
o_byte_ready  out  1  sequencer can accept a byte
o_fft_byte  out  DATA_LENGTH+1  to wrapper byte input; MSB always 0
i_fft_done  in  1  wrapper cycle-done pulse
i_bins_flat  in  N_BINS*2*WORD_SIZE  wrapper outputs; bin k re = [k*2W+W-1 : k*2W], im = [k*2W+2W-1 : k*2W+W], W=WORD_SIZE
o_bin_re  out  WORD_SIZE  streamed bin real part
o_bin_im  out  WORD_SIZE  streamed bin imaginary part
o_bin_idx  out  4  index of presented bin, 0..N_BINS-1
o_bin_valid  out  1  bin beat valid
i_bin_ready  in  1  downstream accepts beat
o_bin_last  out  1  presented bin is N_BINS-1
o_busy  out  1  high in any state other than IDLE
o_timeout  out  1  one-cycle pulse on wait timeout

Behaviour:
- Reset (i_rst=0, asynchronous): state goes to IDLE. All outputs are 0 except o_byte_ready, which is 1 once reset releases. o_fft_byte=0. Bin buffer, done counter and timeout counter clear. Reset asserted mid-operation aborts immediately; no partial beats are emitted afterwards.
- States: IDLE, WAIT, STREAM.
- IDLE:
  - o_byte_ready=1.
  - On i_byte_valid&o_byte_ready: register o_fft_byte={1'b0,i_byte}, clear counters, go to WAIT.
- WAIT:
  - o_byte_ready=0.
  - Done pulses are counted from the cycle after acceptance. A done in the acceptance cycle itself is ignored.
  - The first SKIP_DONES pulses are discarded. On the (SKIP_DONES+1)-th pulse, the buffer registers all of i_bins_flat on that edge and the state goes to STREAM.
  - The timeout counter increments each WAIT cycle. If no qualifying done has been seen by the TIMEOUT_CYCLES-th WAIT cycle, o_timeout pulses for that cycle and the state goes to IDLE without streaming.
  - A qualifying done on the final allowed cycle wins over timeout.
- STREAM:
  - o_bin_valid=1; o_bin_re/o_bin_im = buffer[o_bin_idx], starting at idx 0.
  - Data stays stable while i_bin_ready=0.
  - On valid&ready: idx increments. On the beat with idx=N_BINS-1 (o_bin_last=1), the state goes to IDLE and o_bin_valid drops the next cycle.
  - i_fft_done is ignored in this state. The buffer is not overwritten in this state.
- o_fft_byte holds the last accepted byte through WAIT, STREAM and IDLE until the next acceptance, so the FFT keeps seeing a stable input.
- Latency: first bin becomes valid on the cycle after the capture edge. Best case, with SKIP_DONES=1 and done pulses arriving back to back, acceptance to o_bin_valid is 3 cycles. Minimum symbol throughput is 1 + capture + N_BINS beats.
- No arithmetic is performed on bins; data passes through bit-exact.
- Widths: the done counter is sized for SKIP_DONES+1; the timeout counter is sized for TIMEOUT_CYCLES.

Test Plan:
- Reset with i_rst=0 for 3 cycles mid-STREAM, then release -> o_bin_valid=0, o_busy=0, o_fft_byte=0, o_byte_ready=1; no beats until a new byte is accepted.
- Accept 0xA5, drive i_fft_done at +1 (skipped) and +5 (captured) with bin k re=k, im=0x100+k, i_bin_ready=1 -> o_fft_byte=0x0A5 held; 16 consecutive beats idx 0..15 with re=k, im=0x100+k; o_bin_last only at idx 15; o_byte_ready=1 on the cycle after the last beat.
- Same as above, but toggle i_bin_ready 1/0 each cycle and change i_bins_flat after capture -> 32 cycles of streaming; the captured values are output unchanged; each beat is held while ready is low.
- Accept a byte with i_fft_done high in the acceptance cycle, then one more done at +3 and none after -> the acceptance-cycle done is ignored, the +3 done is skipped; o_timeout pulses exactly once at WAIT cycle 64; no beats are emitted; o_byte_ready=1 afterwards.
- Drive i_byte_valid=1 continuously with 0x11, then 0x22 during WAIT/STREAM -> 0x22 is not accepted until IDLE; o_fft_byte stays 0x011 through the whole first symbol.
- Qualifying done arrives exactly on WAIT cycle 64 -> capture happens, o_timeout stays 0, 16 beats follow.
